// File: rtl/types_pkg.sv
// Shared datapath types for the fetch/decode front end.
package types_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with a flush that wins over same-cycle push/pop.
module fetch_queue #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two depths (e.g. tag FIFO of 3) correct.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-based imem requests, prefetch queue, redirect drop.
module fetch_unit
    import types_pkg::*;
#(
    parameter int unsigned      XLEN            = types_pkg::XLEN,
    parameter int unsigned      DEPTH           = 4,
    parameter int unsigned      MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]  RESET_PC        = '0,
    parameter logic [XLEN-1:0]  PC_STEP         = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING+1);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0] drop_q, drop_d;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] outstanding_next;
    logic [OUT_W-1:0] live;
    logic [OCC_W-1:0] occupancy;
    logic             tag_full, tag_empty, iq_full, iq_empty;
    logic [XLEN-1:0]  tag_head;
    logic             req_fire, rsp_fire, rsp_keep, out_fire, credit;
    fetch_entry_t     iq_push_data, iq_head;

    // The tag FIFO count is the outstanding-request counter.
    fetch_queue #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (1'b0),
        .push_i      (req_fire),
        .push_data_i (fetch_pc_q),
        .pop_i       (rsp_fire),
        .pop_data_o  (tag_head),
        .count_o     (outstanding),
        .full_o      (tag_full),
        .empty_o     (tag_empty)
    );

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_queue (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (redirect_valid),
        .push_i      (rsp_keep),
        .push_data_i (iq_push_data),
        .pop_i       (out_fire),
        .pop_data_o  (iq_head),
        .count_o     (occupancy),
        .full_o      (iq_full),
        .empty_o     (iq_empty)
    );

    // Dropped responses need no queue room, so only live requests reserve space.
    assign live   = outstanding - drop_q;
    assign credit = !tag_full && !iq_full
                    && ((32'(live) + 32'(occupancy)) < DEPTH);

    assign imem_req_valid = reset_n && credit;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && !tag_empty;
    assign rsp_keep       = rsp_fire && (drop_q == '0) && !redirect_valid;

    assign out_valid   = !iq_empty;
    assign out_fire    = out_valid && out_ready;
    assign out_instr   = iq_head.instr;
    assign out_pc      = iq_head.pc;
    assign out_pc_plus = iq_head.pc + PC_STEP;

    always_comb begin
        iq_push_data.instr = imem_rsp_data;
        iq_push_data.pc    = tag_head;
    end

    always_comb begin
        outstanding_next = outstanding + OUT_W'(req_fire) - OUT_W'(rsp_fire);
        fetch_pc_d       = fetch_pc_q;
        drop_d           = drop_q;
        if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (rsp_fire && (drop_q != '0)) drop_d = drop_q - OUT_W'(1);
        // Recomputing from the post-edge count makes back-to-back redirects self-correct.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            drop_d     = outstanding_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

endmodule
